// File: rtl/qspi_pkg.sv
// Shared constants and types for the quad-SPI responder and its initiator.
package qspi_pkg;

    localparam int unsigned WORD_BITS         = 32;
    localparam int unsigned NIBBLES_PER_FIELD = 8;

    localparam logic [7:0] QUAD_READ_CMD  = 8'hEB;
    localparam logic [7:0] QUAD_WRITE_CMD = 8'h32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RDATA,
        ST_WDATA,
        ST_WCOMMIT,
        ST_IGNORE
    } qspi_state_e;

endpackage

// File: rtl/qspi_target_if.sv
// QSPI link plus local memory port seen by the responder (slave) and its environment (master).
interface qspi_target_if #(
    parameter int unsigned ADDR_BITS = 24
);
    logic                           sclk;
    logic                           cs;
    logic [3:0]                     io_in;
    logic [3:0]                     io_out;
    logic [3:0]                     io_oe;
    logic                           mem_req;
    logic                           mem_we;
    logic [ADDR_BITS-1:0]           mem_addr;
    logic [qspi_pkg::WORD_BITS-1:0] mem_wdata;
    logic [qspi_pkg::WORD_BITS-1:0] mem_rdata;
    logic                           mem_ready;
    logic                           busy;
    logic                           rd_underrun;

    modport slave (
        input  sclk, cs, io_in, mem_rdata, mem_ready,
        output io_out, io_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, rd_underrun
    );

    modport master (
        output sclk, cs, io_in, mem_rdata, mem_ready,
        input  io_out, io_oe, mem_req, mem_we, mem_addr, mem_wdata, busy, rd_underrun
    );
endinterface

// File: rtl/qspi_nibble_shift.sv
// 32-bit MSB-first nibble shift register with parallel load and a per-field nibble counter.
module qspi_nibble_shift
    import qspi_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        step_i,
    input  logic        shift_i,
    input  logic        load_i,
    input  logic [31:0] load_data_i,
    input  logic [3:0]  nib_i,
    output logic [31:0] word_o,
    output logic [3:0]  nib_o,
    output logic [2:0]  cnt_o,
    output logic        done_c
);

    localparam logic [2:0] NIB_LAST = 3'(NIBBLES_PER_FIELD - 1);

    logic [31:0] word_q;
    logic [2:0]  cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load_i) begin
                word_q <= load_data_i;
            end else if (shift_i) begin
                word_q <= {word_q[27:0], nib_i};
            end
            if (clr_i) begin
                cnt_q <= '0;
            end else if (step_i) begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

    assign word_o = word_q;
    assign nib_o  = word_q[31:28];
    assign cnt_o  = cnt_q;
    assign done_c = step_i && (cnt_q == NIB_LAST);

endmodule

// File: rtl/qspi_target.sv
// Quad-SPI responder: decodes 0xEB reads and 0x32 writes into single-word memory requests.
module qspi_target
    import qspi_pkg::*;
#(
    parameter int unsigned ADDR_BITS    = 24,
    parameter int unsigned DUMMY_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst,
    qspi_target_if.slave bus
);

    localparam logic [2:0] DUMMY_LAST = 3'(DUMMY_CYCLES - 1);

    qspi_state_e          state_q, state_d;
    logic                 sclk_q;
    logic                 is_wr_q, is_wr_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]          mem_wdata_q, mem_wdata_d;
    logic                 underrun_q, underrun_d;
    logic                 busy_q, busy_d;
    logic [3:0]           io_oe_q, io_oe_d;

    logic                 sr_clr, sr_step, sr_shift, sr_load, sr_done;
    logic [31:0]          sr_load_data, sr_word;
    logic [3:0]           sr_nib;
    logic [2:0]           sr_cnt;

    logic                 rise_c;
    logic [31:0]          word_in_c;

    assign rise_c    = bus.sclk & ~sclk_q;
    assign word_in_c = {sr_word[27:0], bus.io_in};

    qspi_nibble_shift u_shift (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (sr_clr),
        .step_i     (sr_step),
        .shift_i    (sr_shift),
        .load_i     (sr_load),
        .load_data_i(sr_load_data),
        .nib_i      (bus.io_in),
        .word_o     (sr_word),
        .nib_o      (sr_nib),
        .cnt_o      (sr_cnt),
        .done_c     (sr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sclk_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            underrun_q  <= 1'b0;
            busy_q      <= 1'b0;
            io_oe_q     <= 4'h0;
        end else begin
            state_q     <= state_d;
            sclk_q      <= bus.sclk;
            is_wr_q     <= is_wr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            underrun_q  <= underrun_d;
            busy_q      <= busy_d;
            io_oe_q     <= io_oe_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        is_wr_d      = is_wr_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        underrun_d   = 1'b0;
        sr_step      = 1'b0;
        sr_shift     = 1'b0;
        sr_load      = 1'b0;
        sr_load_data = bus.mem_rdata;

        unique case (state_q)
            ST_IDLE: begin
                if (!bus.cs) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (rise_c) begin
                    sr_step  = 1'b1;
                    sr_shift = 1'b1;
                    if (sr_done) begin
                        if (word_in_c[31:8] == 24'd0 && word_in_c[7:0] == QUAD_READ_CMD) begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b0;
                        end else if (word_in_c[31:8] == 24'd0 && word_in_c[7:0] == QUAD_WRITE_CMD) begin
                            state_d = ST_ADDR;
                            is_wr_d = 1'b1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (rise_c) begin
                    sr_step  = 1'b1;
                    sr_shift = 1'b1;
                    if (sr_done) begin
                        mem_addr_d = word_in_c[ADDR_BITS-1:0];
                        if (is_wr_q) begin
                            state_d = ST_WDATA;
                        end else begin
                            state_d   = ST_DUMMY;
                            mem_req_d = 1'b1;
                            mem_we_d  = 1'b0;
                        end
                    end
                end
            end
            ST_DUMMY: begin
                // The shift register doubles as the read buffer while dummy clocks run.
                if (mem_req_q && bus.mem_ready) begin
                    sr_load   = 1'b1;
                    mem_req_d = 1'b0;
                end
                if (rise_c) begin
                    sr_step = 1'b1;
                    if (sr_cnt == DUMMY_LAST) begin
                        state_d   = ST_RDATA;
                        mem_req_d = 1'b0;
                        if (mem_req_q && !bus.mem_ready) begin
                            sr_load      = 1'b1;
                            sr_load_data = '0;
                            underrun_d   = 1'b1;
                        end
                    end
                end
            end
            ST_RDATA: begin
                if (rise_c) begin
                    sr_step  = 1'b1;
                    sr_shift = 1'b1;
                    if (sr_done) state_d = ST_IGNORE;
                end
            end
            ST_WDATA: begin
                if (rise_c) begin
                    sr_step  = 1'b1;
                    sr_shift = 1'b1;
                    if (sr_done) begin
                        mem_wdata_d = word_in_c;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        state_d     = ST_WCOMMIT;
                    end
                end
            end
            ST_WCOMMIT: begin
                if (bus.mem_ready) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = bus.cs ? ST_IDLE : ST_IGNORE;
                end
            end
            ST_IGNORE: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A committed write must finish; everything else aborts on deselect.
        if (bus.cs && state_q != ST_IDLE && state_q != ST_WCOMMIT) begin
            state_d    = ST_IDLE;
            mem_req_d  = 1'b0;
            mem_we_d   = 1'b0;
            underrun_d = 1'b0;
        end

        sr_clr  = (state_d != state_q);
        busy_d  = (state_d != ST_IDLE);
        io_oe_d = (state_d == ST_RDATA) ? 4'hF : 4'h0;
    end

    assign bus.io_out      = sr_nib & io_oe_q;
    assign bus.io_oe       = io_oe_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.busy        = busy_q;
    assign bus.rd_underrun = underrun_q;

endmodule

// File: tb/tb_qspi_target.sv
// Drives qspi_target as a 2-clk-sclk initiator against a bench RAM and a reference memory model.
module tb_qspi_target;

    localparam int unsigned ADDR_BITS    = 24;
    localparam int unsigned DUMMY_CYCLES = 4;
    localparam int          BUDGET       = 2 * DUMMY_CYCLES - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qspi_target_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    qspi_target #(.ADDR_BITS(ADDR_BITS), .DUMMY_CYCLES(DUMMY_CYCLES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench RAM (environment) and the independent reference memory.
    logic [31:0] store   [logic [ADDR_BITS-1:0]];
    logic [31:0] ref_mem [logic [ADDR_BITS-1:0]];

    function automatic logic [31:0] dflt(input logic [ADDR_BITS-1:0] a);
        return {a[7:0] ^ 8'h5A, a};
    endfunction

    function automatic logic [31:0] ram_rd(input logic [ADDR_BITS-1:0] a);
        if (store.exists(a)) return store[a];
        return dflt(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [ADDR_BITS-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return dflt(a);
    endfunction

    // Memory responder: ready after the request has been visible rdy_delay cycles.
    int rdy_delay = 0;
    bit rdy_tie   = 1'b0;
    int req_age   = 0;
    always @(posedge clk) begin
        #1;
        if (bus.mem_req) req_age = req_age + 1;
        else             req_age = 0;
        bus.mem_ready = rdy_tie || (bus.mem_req && req_age == rdy_delay + 1);
        bus.mem_rdata = bus.mem_req ? ram_rd(bus.mem_addr) : 32'h0;
    end

    // Bus monitor.
    int                   wr_cycles = 0, rd_cycles = 0, oe_cycles = 0, ur_cycles = 0;
    logic [ADDR_BITS-1:0] wr_addr, rd_addr;
    logic [31:0]          wr_data;
    logic                 prev_req = 1'b0;
    logic [63:0]          prev_pay;
    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_we) begin
            wr_cycles++;
            wr_addr = bus.mem_addr;
            wr_data = bus.mem_wdata;
            if (bus.mem_ready) store[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.mem_req && !bus.mem_we) begin
            rd_cycles++;
            rd_addr = bus.mem_addr;
        end
        if (bus.io_oe == 4'hF) oe_cycles++;
        if (bus.rd_underrun) ur_cycles++;
        if (bus.mem_req && prev_req)
            check("req_stable", {7'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata}, prev_pay);
        prev_req = bus.mem_req;
        prev_pay = {7'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // One sclk period: low clk then high clk; io_out is captured during the high clk.
    task automatic period(input logic [3:0] nib, output logic [3:0] cap, output logic [3:0] oe);
        bus.sclk  = 1'b0;
        bus.io_in = nib;
        cyc();
        bus.sclk = 1'b1;
        cap      = bus.io_out;
        oe       = bus.io_oe;
        cyc();
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [3:0] cap, oe;
        for (int i = 0; i < 8; i++) period(w[31-4*i -: 4], cap, oe);
    endtask

    task automatic finish_cs();
        bus.sclk = 1'b0;
        cyc();
        bus.cs = 1'b1;
        cyc();
        cyc();
    endtask

    task automatic do_read(input logic [31:0] aw, input int d);
        logic [3:0]  cap, oe;
        logic [31:0] got;
        logic [31:0] exp;
        int          rd0, oe0, ur0, exp_req;
        rdy_delay = d;
        rd0 = rd_cycles; oe0 = oe_cycles; ur0 = ur_cycles;
        exp     = (d <= BUDGET) ? ref_rd(aw[ADDR_BITS-1:0]) : 32'h0;
        exp_req = (d + 1 < 2 * DUMMY_CYCLES) ? d + 1 : 2 * DUMMY_CYCLES;
        got = '0;
        bus.cs = 1'b0;
        send_word(32'h0000_00EB);
        send_word(aw);
        for (int k = 0; k < DUMMY_CYCLES; k++) begin
            period(4'($urandom_range(15)), cap, oe);
            check("dummy_oe", 64'(oe), 64'h0);
        end
        for (int k = 0; k < 8; k++) begin
            period(4'($urandom_range(15)), cap, oe);
            got = {got[27:0], cap};
            check("rdata_oe", 64'(oe), 64'hF);
        end
        finish_cs();
        check("rd_data", 64'(got), 64'(exp));
        check("rd_busy_end", 64'(bus.busy), 64'h0);
        check("rd_req_cycles", 64'(rd_cycles - rd0), 64'(exp_req));
        check("rd_addr", 64'(rd_addr), 64'(aw[ADDR_BITS-1:0]));
        check("rd_oe_cycles", 64'(oe_cycles - oe0), 64'd16);
        check("rd_underrun", 64'(ur_cycles - ur0), (d > BUDGET) ? 64'd1 : 64'd0);
    endtask

    task automatic do_write(input logic [31:0] aw, input logic [31:0] data, input int d);
        int wr0;
        rdy_delay = d;
        wr0 = wr_cycles;
        bus.cs = 1'b0;
        send_word(32'h0000_0032);
        send_word(aw);
        send_word(data);
        bus.sclk = 1'b0;
        bus.cs   = 1'b1;
        for (int k = 0; k <= d; k++) begin
            check("wr_busy_hold", 64'(bus.busy), 64'h1);
            check("wr_req_hold", 64'({bus.mem_req, bus.mem_we}), 64'h3);
            cyc();
        end
        check("wr_busy_fall", 64'(bus.busy), 64'h0);
        check("wr_req_cycles", 64'(wr_cycles - wr0), 64'(d + 1));
        check("wr_addr", 64'(wr_addr), 64'(aw[ADDR_BITS-1:0]));
        check("wr_data", 64'(wr_data), 64'(data));
        ref_mem[aw[ADDR_BITS-1:0]] = data;
    endtask

    task automatic do_ignore(input logic [31:0] cmd);
        int wr0, rd0, oe0;
        wr0 = wr_cycles; rd0 = rd_cycles; oe0 = oe_cycles;
        bus.cs = 1'b0;
        send_word(cmd);
        check("ign_busy", 64'(bus.busy), 64'h1);
        for (int k = 0; k < 16; k++) send_word({$urandom} & 32'h0000_000F);
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        cyc();
        check("ign_idle", 64'(bus.busy), 64'h0);
        check("ign_no_req", 64'((wr_cycles - wr0) + (rd_cycles - rd0)), 64'h0);
        check("ign_no_oe", 64'(oe_cycles - oe0), 64'h0);
    endtask

    task automatic reset_mid_read(input bit in_data);
        logic [3:0] cap, oe;
        rdy_delay = 100;
        bus.cs = 1'b0;
        send_word(32'h0000_00EB);
        send_word(32'h0000_0456);
        if (!in_data) begin
            for (int k = 0; k < 2; k++) period(4'h0, cap, oe);
            check("rst_pre_req", 64'(bus.mem_req), 64'h1);
        end else begin
            for (int k = 0; k < DUMMY_CYCLES + 3; k++) period(4'h0, cap, oe);
            check("rst_pre_oe", 64'(bus.io_oe), 64'hF);
        end
        #1 rst = 1'b1;
        #1;
        check("rst_async_oe", 64'(bus.io_oe), 64'h0);
        check("rst_async_req", 64'(bus.mem_req), 64'h0);
        cyc();
        rst      = 1'b0;
        bus.cs   = 1'b1;
        bus.sclk = 1'b0;
        cyc();
        cyc();
        check("rst_busy_after", 64'(bus.busy), 64'h0);
        rdy_delay = 0;
    endtask

    logic [ADDR_BITS-1:0] written [$];

    initial begin
        bus.sclk  = 1'b0;
        bus.cs    = 1'b1;
        bus.io_in = 4'h0;
        rst       = 1'b1;
        repeat (3) cyc();
        check("rst_io_out", 64'(bus.io_out), 64'h0);
        check("rst_io_oe", 64'(bus.io_oe), 64'h0);
        check("rst_mem_req", 64'({bus.mem_req, bus.mem_we}), 64'h0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        check("rst_busy_ur", 64'({bus.busy, bus.rd_underrun}), 64'h0);
        rst = 1'b0;
        cyc();

        rdy_tie = 1'b1;
        do_write(32'h0000_0123, 32'hDEAD_BEEF, 0);
        rdy_tie = 1'b0;

        store[24'h000123]   = 32'hCAFE_F00D;
        ref_mem[24'h000123] = 32'hCAFE_F00D;
        do_read(32'h0000_0123, 3);

        do_ignore(32'h0000_009F);
        do_ignore(32'h0100_00EB);

        // Partial write: deselect after 5 data nibbles.
        begin
            int wr0;
            logic [3:0] cap, oe;
            wr0 = wr_cycles;
            bus.cs = 1'b0;
            send_word(32'h0000_0032);
            send_word(32'h0000_0777);
            for (int k = 0; k < 5; k++) period(4'hA, cap, oe);
            bus.cs   = 1'b1;
            bus.sclk = 1'b0;
            cyc();
            check("abort_idle", 64'(bus.busy), 64'h0);
            cyc();
            check("abort_no_req", 64'(wr_cycles - wr0), 64'h0);
        end
        do_read(32'h0000_0777, 0);

        do_read(32'h0000_0123, 12);
        do_read(32'hFF00_0123, BUDGET);
        do_read(32'h0000_0123, BUDGET + 1);

        reset_mid_read(1'b0);
        reset_mid_read(1'b1);

        for (int i = 0; i < 12; i++) begin
            logic [31:0] aw, dw;
            aw = $urandom;
            dw = $urandom;
            do_write(aw, dw, int'($urandom_range(4)));
            written.push_back(aw[ADDR_BITS-1:0]);
        end
        for (int i = 0; i < 12; i++) begin
            logic [31:0] aw;
            aw = $urandom;
            if (i % 2 == 0) aw[ADDR_BITS-1:0] = written[$urandom_range(written.size() - 1)];
            do_read(aw, int'($urandom_range(BUDGET + 4)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
